// File: rtl/rgb_pkg.sv
// Shared colour-index and mode definitions for the RGB select front-end and PWM stage.
package rgb_pkg;

  localparam logic [1:0] COLOR_VIOLET = 2'd0;
  localparam logic [1:0] COLOR_BLUE   = 2'd1;
  localparam logic [1:0] COLOR_GOLD   = 2'd2;
  localparam logic [1:0] COLOR_ORANGE = 2'd3;

  typedef enum logic {
    MODE_MANUAL = 1'b0,
    MODE_AUTO   = 1'b1
  } mode_t;

  // Colour stepping wraps 3 -> 0 in plain 2-bit arithmetic.
  function automatic logic [1:0] next_color(input logic [1:0] c);
    return c + 2'd1;
  endfunction

endpackage

// File: rtl/rgb_sel_ctrl_if.sv
// Button inputs and colour-select outputs of rgb_sel_ctrl, grouped as one bundle.
interface rgb_sel_ctrl_if;
  import rgb_pkg::*;

  logic       btn_next;
  logic       btn_mode;
  logic [1:0] sel;
  logic       auto_mode;
  logic       sel_changed;

  modport master (output btn_next, btn_mode, input sel, auto_mode, sel_changed);
  modport slave  (input btn_next, btn_mode, output sel, auto_mode, sel_changed);

endinterface

// File: rtl/btn_debounce.sv
// Raw button -> 2-flop synchroniser -> debouncer -> registered rising-edge press pulse.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1, sync2;
  logic          level, level_d;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      level   <= 1'b0;
      level_d <= 1'b0;
      press   <= 1'b0;
      cnt     <= '0;
    end else begin
      sync1   <= btn;
      sync2   <= sync1;
      level_d <= level;
      press   <= level & ~level_d;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= ~level;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/rgb_sel_ctrl.sv
// Button-driven colour select with MANUAL/AUTO mode FSM.
// AUTO mode, dwell counter and the btn_mode chain exist only when RGB_SEL_AUTO_EN is defined.
module rgb_sel_ctrl
  import rgb_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned DWELL_CYCLES    = 100_000_000
) (
  input logic          clk,
  input logic          rst,
  rgb_sel_ctrl_if.slave bus
);

  if (DEBOUNCE_CYCLES < 1 || DWELL_CYCLES < 2) begin : g_param_check
    $error("rgb_sel_ctrl: DEBOUNCE_CYCLES must be >= 1 and DWELL_CYCLES >= 2");
  end

  logic       next_press;
  logic [1:0] sel, sel_n;
  logic       sel_changed;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_next (
    .clk   (clk),
    .rst   (rst),
    .btn   (bus.btn_next),
    .press (next_press)
  );

`ifdef RGB_SEL_AUTO_EN
  localparam int unsigned DW = $clog2(DWELL_CYCLES);
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYCLES - 1);

  logic          mode_press;
  mode_t         state, state_n;
  logic [DW-1:0] dwell, dwell_n;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode (
    .clk   (clk),
    .rst   (rst),
    .btn   (bus.btn_mode),
    .press (mode_press)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= MODE_MANUAL;
      dwell <= '0;
    end else begin
      state <= state_n;
      dwell <= dwell_n;
    end
  end

  // Mode press outranks both next press and dwell expiry; dwell stays cleared outside AUTO.
  always_comb begin
    state_n = state;
    sel_n   = sel;
    dwell_n = '0;
    case (state)
      MODE_MANUAL: begin
        if (mode_press)      state_n = MODE_AUTO;
        else if (next_press) sel_n   = next_color(sel);
      end
      MODE_AUTO: begin
        if (mode_press)                              state_n = MODE_MANUAL;
        else if (next_press || dwell == DWELL_LAST)  sel_n   = next_color(sel);
        else                                         dwell_n = dwell + DW'(1);
      end
      default: state_n = MODE_MANUAL;
    endcase
  end

  assign bus.auto_mode = (state == MODE_AUTO);
`else
  always_comb begin
    sel_n = sel;
    if (next_press) sel_n = next_color(sel);
  end

  assign bus.auto_mode = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel         <= COLOR_VIOLET;
      sel_changed <= 1'b0;
    end else begin
      sel         <= sel_n;
      sel_changed <= (sel_n != sel);
    end
  end

  assign bus.sel         = sel;
  assign bus.sel_changed = sel_changed;

endmodule

// File: tb/tb_rgb_sel_ctrl.sv
// Self-checking bench for rgb_sel_ctrl: table vectors, corner-case sequences and random stimulus
// against a window-based reference model. AUTO sequences run when RGB_SEL_AUTO_EN is defined.
module tb_rgb_sel_ctrl;

  localparam int unsigned D = 4;
  localparam int unsigned W = 10;

  logic clk = 1'b0;
  logic rst;
  rgb_sel_ctrl_if bus ();

  rgb_sel_ctrl #(.DEBOUNCE_CYCLES(D), .DWELL_CYCLES(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int unsigned tests = 0;
  int unsigned failures = 0;

  // Reference model: a level is accepted once D consecutive synchronised samples
  // disagree with it; synchronised sample before edge n is the raw value seen at edge n-2.
  bit hist_n[$];
  bit deb_n, rose_n, prs_n;
`ifdef RGB_SEL_AUTO_EN
  bit hist_m[$];
  bit deb_m, rose_m, prs_m;
  int unsigned last_clear;
`endif
  int  m_sel;
  bit  m_auto, m_chg;
  int unsigned edge_no = 0;

  function automatic bit window_differs(input bit h[$], input bit lvl);
    for (int unsigned i = 0; i < D; i++)
      if (h[i] == lvl) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    hist_n = {};
    for (int unsigned i = 0; i < D + 2; i++) hist_n.push_back(1'b0);
    deb_n = 0; rose_n = 0; prs_n = 0;
`ifdef RGB_SEL_AUTO_EN
    hist_m = {};
    for (int unsigned i = 0; i < D + 2; i++) hist_m.push_back(1'b0);
    deb_m = 0; rose_m = 0; prs_m = 0;
    last_clear = 0;
`endif
    m_sel = 0; m_auto = 0; m_chg = 0;
  endtask

  task automatic model_edge();
    bit p_n, f_n;
    int prev;
`ifdef RGB_SEL_AUTO_EN
    bit p_m, f_m;
`endif
    edge_no++;
    if (rst) begin
      model_reset();
      return;
    end
    hist_n.push_back(bus.btn_next);
    void'(hist_n.pop_front());
    p_n = prs_n; prs_n = rose_n;
    f_n = window_differs(hist_n, deb_n);
    if (f_n) deb_n = !deb_n;
    rose_n = f_n && deb_n;
    prev = m_sel;
`ifdef RGB_SEL_AUTO_EN
    hist_m.push_back(bus.btn_mode);
    void'(hist_m.pop_front());
    p_m = prs_m; prs_m = rose_m;
    f_m = window_differs(hist_m, deb_m);
    if (f_m) deb_m = !deb_m;
    rose_m = f_m && deb_m;
    if (p_m) begin
      m_auto = !m_auto;
      last_clear = edge_no;
    end else if (m_auto) begin
      if (p_n || (edge_no - last_clear == W)) begin
        m_sel = (m_sel + 1) % 4;
        last_clear = edge_no;
      end
    end else if (p_n) begin
      m_sel = (m_sel + 1) % 4;
    end
`else
    if (p_n) m_sel = (m_sel + 1) % 4;
`endif
    m_chg = (m_sel != prev);
  endtask

  task automatic compare_model(input string name);
    tests++;
    if (bus.sel !== 2'(m_sel) || bus.auto_mode !== m_auto || bus.sel_changed !== m_chg) begin
      failures++;
      $display("FAIL %s @edge %0d: sel=%0d auto=%0b chg=%0b, expected sel=%0d auto=%0b chg=%0b",
               name, edge_no, bus.sel, bus.auto_mode, bus.sel_changed, m_sel, m_auto, m_chg);
    end
  endtask

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      model_edge();
      #1;
      compare_model("model");
    end
  endtask

  task automatic set_rst(input bit v);
    rst = v;
    if (v) model_reset();
    #1;
    compare_model("async_rst");
  endtask

  task automatic pulse_reset();
    set_rst(1'b1);
    tick(1);
    set_rst(1'b0);
  endtask

  typedef struct {
    bit          nxt;
    int unsigned cycles;
    logic [1:0]  exp_sel;
  } vec_t;

  vec_t vecs[$];
  int unsigned pulses;

  initial begin
    rst = 1'b1;
    bus.btn_next = 1'b0;
    bus.btn_mode = 1'b0;
    model_reset();
    tick(2);
    check("reset_sel", bus.sel, 0);
    check("reset_auto", bus.auto_mode, 0);
    check("reset_chg", bus.sel_changed, 0);
    set_rst(1'b0);

    // Glitches shorter than D, then four full presses walking 1,2,3,0.
    for (int i = 0; i < 5; i++) begin
      vecs.push_back('{1'b1, 3, 2'd0});
      vecs.push_back('{1'b0, 3, 2'd0});
    end
    vecs.push_back('{1'b0, 10, 2'd0});
    vecs.push_back('{1'b1, 8, 2'd1}); vecs.push_back('{1'b0, 8, 2'd1});
    vecs.push_back('{1'b1, 8, 2'd2}); vecs.push_back('{1'b0, 8, 2'd2});
    vecs.push_back('{1'b1, 8, 2'd3}); vecs.push_back('{1'b0, 8, 2'd3});
    vecs.push_back('{1'b1, 8, 2'd0}); vecs.push_back('{1'b0, 8, 2'd0});
    for (int i = 0; i < vecs.size(); i++) begin
      bus.btn_next = vecs[i].nxt;
      tick(vecs[i].cycles);
      check($sformatf("vec%0d_sel", i), bus.sel, vecs[i].exp_sel);
    end

    // Long hold: exactly one step, landing on edge D+4 = 8.
    pulse_reset();
    bus.btn_next = 1'b1;
    tick(7);
    check("hold_sel_e7", bus.sel, 0);
    tick(1);
    check("hold_sel_e8", bus.sel, 1);
    check("hold_chg_e8", bus.sel_changed, 1);
    pulses = 0;
    repeat (12) begin
      tick(1);
      if (bus.sel_changed) pulses++;
    end
    check("hold_extra_pulses", pulses, 0);
    check("hold_sel_end", bus.sel, 1);
    bus.btn_next = 1'b0;
    tick(10);

    // Reset with button held: counts are discarded and the held level re-debounces into a press.
    pulse_reset();
    bus.btn_next = 1'b1; tick(8); bus.btn_next = 1'b0; tick(8);
    bus.btn_next = 1'b1; tick(8); bus.btn_next = 1'b0; tick(8);
    check("pre_rst_sel", bus.sel, 2);
    bus.btn_next = 1'b1;
    tick(3);
    set_rst(1'b1);
    check("mid_rst_sel", bus.sel, 0);
    check("mid_rst_chg", bus.sel_changed, 0);
    tick(2);
    set_rst(1'b0);
    tick(7);
    check("post_rst_sel_e7", bus.sel, 0);
    tick(1);
    check("post_rst_sel_e8", bus.sel, 1);
    check("post_rst_chg_e8", bus.sel_changed, 1);
    bus.btn_next = 1'b0;
    tick(10);

    pulse_reset();
`ifdef RGB_SEL_AUTO_EN
    bus.btn_mode = 1'b1; tick(8);
    check("auto_enter", bus.auto_mode, 1);
    check("auto_enter_sel", bus.sel, 0);
    bus.btn_mode = 1'b0;
    tick(9);
    check("auto_dwell_e9", bus.sel, 0);
    tick(1);
    check("auto_step1", bus.sel, 1);
    check("auto_step1_chg", bus.sel_changed, 1);
    tick(10); check("auto_step2", bus.sel, 2);
    tick(10); check("auto_step3", bus.sel, 3);
    tick(10); check("auto_step_wrap", bus.sel, 0);
    bus.btn_mode = 1'b1; tick(8);
    check("auto_exit", bus.auto_mode, 0);
    bus.btn_mode = 1'b0; tick(30);
    check("manual_frozen", bus.sel, 0);

    // Next press lands on the dwell-expiry edge: one step, dwell restarts.
    bus.btn_mode = 1'b1; tick(8);
    check("auto_reenter", bus.auto_mode, 1);
    bus.btn_mode = 1'b0; tick(2);
    bus.btn_next = 1'b1; tick(8);
    check("align_sel", bus.sel, 1);
    bus.btn_next = 1'b0; tick(9);
    check("align_hold", bus.sel, 1);
    tick(1);
    check("align_next_step", bus.sel, 2);

    bus.btn_next = 1'b1; bus.btn_mode = 1'b1; tick(8);
    check("both_auto", bus.auto_mode, 0);
    check("both_sel", bus.sel, 2);
    bus.btn_next = 1'b0; bus.btn_mode = 1'b0; tick(12);
`else
    bus.btn_mode = 1'b1; tick(12);
    check("mode_ignored_auto", bus.auto_mode, 0);
    check("mode_ignored_sel", bus.sel, 0);
    bus.btn_mode = 1'b0; tick(8);
`endif

    // Random button activity with occasional resets, checked every cycle against the model.
    for (int i = 0; i < 250; i++) begin
      bus.btn_next = 1'($urandom_range(0, 1));
      bus.btn_mode = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 39) == 0) pulse_reset();
      tick($urandom_range(1, 12));
    end
    bus.btn_next = 1'b0;
    bus.btn_mode = 1'b0;
    tick(10);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
